// File: rtl/btb_assoc_if.sv
// Fetch-side lookup and EX-side update bus of the set-associative branch target buffer.
// master = core side, slave = BTB.
interface btb_assoc_if #(
   parameter int unsigned ADDR_W = 32
) ();
   logic              flush;
   logic [ADDR_W-1:0] pc;
   logic              pred_hit;
   logic              pred_taken;
   logic [ADDR_W-1:0] pred_target;
   logic              upd_valid;
   logic [ADDR_W-1:0] upd_pc;
   logic              upd_taken;
   logic [ADDR_W-1:0] upd_target;

   modport master (
      output flush, pc, upd_valid, upd_pc, upd_taken, upd_target,
      input  pred_hit, pred_taken, pred_target
   );

   modport slave (
      input  flush, pc, upd_valid, upd_pc, upd_taken, upd_target,
      output pred_hit, pred_taken, pred_target
   );
endinterface

// File: rtl/btb_assoc.sv
// Set-associative BTB: combinational lookup on the fetch PC, registered update from EX,
// saturating direction counters and per-set round-robin replacement.
module btb_assoc #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned SETS   = 16,
   parameter int unsigned WAYS   = 2,
   parameter int unsigned CNT_W  = 2
) (
   input logic       clk,
   input logic       rst,
   btb_assoc_if.slave bus
);
   localparam int unsigned IDX_W = $clog2(SETS);
   localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] WEAK_T  = CNT_W'(1 << (CNT_W - 1));
   localparam logic [CNT_W-1:0] WEAK_NT = CNT_W'((1 << (CNT_W - 1)) - 1);

   logic              valid_q  [SETS][WAYS];
   logic [TAG_W-1:0]  tag_q    [SETS][WAYS];
   logic [ADDR_W-1:0] target_q [SETS][WAYS];
   logic [CNT_W-1:0]  cnt_q    [SETS][WAYS];
   logic [WAY_W-1:0]  rr_q     [SETS];

   logic [IDX_W-1:0] lk_idx, up_idx;
   logic [TAG_W-1:0] lk_tag, up_tag;
   logic             lk_hit, lk_taken;
   logic [WAY_W-1:0] lk_way;

   logic             up_hit, all_valid, rr_adv, tgt_wr;
   logic [WAY_W-1:0] up_way, inv_way, wr_way, rr_nxt;
   logic [CNT_W-1:0] cnt_cur, cnt_inc, cnt_dec, wr_cnt;

   logic unused_pc_lsb;
   assign unused_pc_lsb = ^{bus.pc[1:0], bus.upd_pc[1:0]};

   assign lk_idx = bus.pc[IDX_W+1:2];
   assign lk_tag = bus.pc[ADDR_W-1:IDX_W+2];
   assign up_idx = bus.upd_pc[IDX_W+1:2];
   assign up_tag = bus.upd_pc[ADDR_W-1:IDX_W+2];

   // Descending scan so the lowest matching way is the one left standing.
   always_comb begin
      lk_hit = 1'b0;
      lk_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
            lk_hit = 1'b1;
            lk_way = WAY_W'(w);
         end
      end
   end

   assign lk_taken        = lk_hit & cnt_q[lk_idx][lk_way][CNT_W-1];
   assign bus.pred_hit    = lk_hit;
   assign bus.pred_taken  = lk_taken;
   assign bus.pred_target = lk_taken ? target_q[lk_idx][lk_way] : '0;

   always_comb begin
      up_hit    = 1'b0;
      up_way    = '0;
      all_valid = 1'b1;
      inv_way   = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[up_idx][w] && tag_q[up_idx][w] == up_tag) begin
            up_hit = 1'b1;
            up_way = WAY_W'(w);
         end
         if (!valid_q[up_idx][w]) begin
            all_valid = 1'b0;
            inv_way   = WAY_W'(w);
         end
      end
   end

   always_comb begin
      cnt_cur = cnt_q[up_idx][up_way];
      cnt_inc = (cnt_cur == CNT_MAX) ? cnt_cur : cnt_cur + CNT_W'(1);
      cnt_dec = (cnt_cur == '0) ? cnt_cur : cnt_cur - CNT_W'(1);
      rr_nxt  = (WAYS == 1) ? '0 : rr_q[up_idx] + WAY_W'(1);
      if (up_hit) begin
         wr_way = up_way;
         wr_cnt = bus.upd_taken ? cnt_inc : cnt_dec;
      end else begin
         wr_way = all_valid ? rr_q[up_idx] : inv_way;
         wr_cnt = bus.upd_taken ? WEAK_T : WEAK_NT;
      end
      // A hit keeps the old target on not-taken; a fill always takes the new one.
      tgt_wr = !up_hit || bus.upd_taken;
      rr_adv = !up_hit && all_valid;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            rr_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               valid_q[s][w]  <= 1'b0;
               tag_q[s][w]    <= '0;
               target_q[s][w] <= '0;
               cnt_q[s][w]    <= '0;
            end
         end
      end else if (bus.flush) begin
         for (int s = 0; s < SETS; s++) begin
            rr_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               valid_q[s][w] <= 1'b0;
            end
         end
      end else if (bus.upd_valid) begin
         valid_q[up_idx][wr_way] <= 1'b1;
         tag_q[up_idx][wr_way]   <= up_tag;
         cnt_q[up_idx][wr_way]   <= wr_cnt;
         if (tgt_wr) begin
            target_q[up_idx][wr_way] <= bus.upd_target;
         end
         if (rr_adv) begin
            rr_q[up_idx] <= rr_nxt;
         end
      end
   end
endmodule

// File: tb/tb_btb_assoc.sv
// Scoreboard bench for btb_assoc: expected predictions are queued when a lookup is driven
// and popped against the DUT outputs half a cycle later.
module tb_btb_assoc;
   logic clk = 1'b0;
   logic rst = 1'b1;

   btb_assoc_if #(.ADDR_W(32)) bus ();

   btb_assoc #(
      .ADDR_W(32),
      .SETS  (16),
      .WAYS  (2),
      .CNT_W (2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        hit;
      logic        taken;
      logic [31:0] tgt;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic expect_out(input logic h, input logic t, input logic [31:0] tgt);
      exp_t e;
      e.hit   = h;
      e.taken = t;
      e.tgt   = tgt;
      exp_q.push_back(e);
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL %s: got empty scoreboard, expected an entry", tag);
      end else begin
         e = exp_q.pop_front();
         check_val({tag, ".hit"}, 32'(bus.pred_hit), 32'(e.hit));
         check_val({tag, ".taken"}, 32'(bus.pred_taken), 32'(e.taken));
         check_val({tag, ".target"}, bus.pred_target, e.tgt);
      end
   endtask

   task automatic look(input string tag, input logic [31:0] addr, input logic h, input logic t,
                       input logic [31:0] tgt);
      bus.pc = addr;
      expect_out(h, t, tgt);
      @(negedge clk);
      check_out(tag);
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic v, input logic [31:0] addr, input logic t,
                      input logic [31:0] tgt);
      bus.upd_valid  = v;
      bus.upd_pc     = addr;
      bus.upd_taken  = t;
      bus.upd_target = tgt;
      @(posedge clk);
      #1;
      bus.upd_valid = 1'b0;
   endtask

   initial begin
      bus.flush      = 1'b0;
      bus.pc         = '0;
      bus.upd_valid  = 1'b0;
      bus.upd_pc     = '0;
      bus.upd_taken  = 1'b0;
      bus.upd_target = '0;
      #12 rst = 1'b0;
      @(posedge clk);
      #1;

      look("reset", 32'h100, 1'b0, 1'b0, 32'h0);

      // Counter walk on one entry
      upd(1'b1, 32'h100, 1'b1, 32'h200);
      look("alloc_t", 32'h100, 1'b1, 1'b1, 32'h200);
      upd(1'b1, 32'h100, 1'b0, 32'h999);
      look("cnt1", 32'h100, 1'b1, 1'b0, 32'h0);
      upd(1'b1, 32'h100, 1'b0, 32'h999);
      look("cnt0", 32'h100, 1'b1, 1'b0, 32'h0);
      upd(1'b1, 32'h100, 1'b0, 32'h999);
      upd(1'b1, 32'h100, 1'b1, 32'h204);
      look("sat_lo", 32'h100, 1'b1, 1'b0, 32'h0);
      upd(1'b1, 32'h100, 1'b1, 32'h208);
      look("back_t", 32'h100, 1'b1, 1'b1, 32'h208);
      for (int i = 0; i < 4; i++) upd(1'b1, 32'h100, 1'b1, 32'h200);
      look("sat_hi", 32'h100, 1'b1, 1'b1, 32'h200);
      upd(1'b1, 32'h100, 1'b0, 32'h999);
      look("cnt2", 32'h100, 1'b1, 1'b1, 32'h200);
      upd(1'b1, 32'h100, 1'b0, 32'h999);
      look("cnt1b", 32'h100, 1'b1, 1'b0, 32'h0);

      // Flush wins over a simultaneous update
      bus.flush = 1'b1;
      upd(1'b1, 32'h500, 1'b1, 32'h600);
      bus.flush = 1'b0;
      look("flush_old", 32'h100, 1'b0, 1'b0, 32'h0);
      look("flush_drop", 32'h500, 1'b0, 1'b0, 32'h0);

      upd(1'b0, 32'h600, 1'b1, 32'h700);
      look("no_valid", 32'h600, 1'b0, 1'b0, 32'h0);

      // Conflicts in set 0
      upd(1'b1, 32'h100, 1'b1, 32'h200);
      upd(1'b1, 32'h140, 1'b1, 32'h240);
      look("fill_w0", 32'h100, 1'b1, 1'b1, 32'h200);
      look("fill_w1", 32'h140, 1'b1, 1'b1, 32'h240);
      upd(1'b1, 32'h180, 1'b1, 32'h280);
      look("evict0_a", 32'h100, 1'b0, 1'b0, 32'h0);
      look("evict0_b", 32'h140, 1'b1, 1'b1, 32'h240);
      look("evict0_c", 32'h180, 1'b1, 1'b1, 32'h280);
      upd(1'b1, 32'h104, 1'b1, 32'h304);
      look("set1", 32'h104, 1'b1, 1'b1, 32'h304);
      upd(1'b1, 32'h1C0, 1'b1, 32'h2C0);
      look("evict1_a", 32'h140, 1'b0, 1'b0, 32'h0);
      look("evict1_b", 32'h180, 1'b1, 1'b1, 32'h280);
      look("evict1_c", 32'h1C0, 1'b1, 1'b1, 32'h2C0);
      upd(1'b1, 32'h100, 1'b1, 32'h200);
      look("rr_wrap_a", 32'h180, 1'b0, 1'b0, 32'h0);
      look("rr_wrap_b", 32'h1C0, 1'b1, 1'b1, 32'h2C0);
      look("rr_wrap_c", 32'h100, 1'b1, 1'b1, 32'h200);
      look("set1_kept", 32'h104, 1'b1, 1'b1, 32'h304);

      // Same-cycle lookup and update: no bypass
      bus.pc = 32'h100;
      bus.upd_valid  = 1'b1;
      bus.upd_pc     = 32'h100;
      bus.upd_taken  = 1'b1;
      bus.upd_target = 32'h300;
      expect_out(1'b1, 1'b1, 32'h200);
      @(negedge clk);
      check_out("same_cyc");
      @(posedge clk);
      #1;
      bus.upd_valid = 1'b0;
      look("next_cyc", 32'h100, 1'b1, 1'b1, 32'h300);

      // Asynchronous reset between edges
      bus.pc = 32'h100;
      #2;
      expect_out(1'b1, 1'b1, 32'h300);
      check_out("pre_rst");
      rst = 1'b1;
      #1;
      expect_out(1'b0, 1'b0, 32'h0);
      check_out("async_rst");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      look("post_rst_a", 32'h100, 1'b0, 1'b0, 32'h0);
      look("post_rst_b", 32'h1C0, 1'b0, 1'b0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
